mem_loader: RTL and testbench

Program loader that sits directly upstream of `Memory_Unit` in the RISC-SPM. It accepts a byte stream over a valid/ready handshake and writes it into consecutive memory locations starting at a programmable base address. While loading, it holds the CPU and computes a running checksum. An optional read-back pass re-reads the loaded region and flags any mismatch before the CPU is released.

---
 rtl/mem_loader.sv | 158 +++++++++++++++
 tb/tb_mem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: streams bytes from a valid/ready source into consecutive
// Memory_Unit locations starting at a programmable base address, holding the
// CPU off memory while it works and keeping a running modulo checksum.
// Optional feature macro: MEM_LOADER_VERIFY_EN adds a read-back pass that
// re-sums the loaded region and raises verify_err on a checksum mismatch.
module mem_loader #(
  parameter int WORD_SIZE = 8,
  parameter int MEM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] base_addr,
  input  logic [WORD_SIZE:0]   length,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [WORD_SIZE-1:0] mem_data_out,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] checksum,
  output logic                 verify_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [WORD_SIZE:0] ONE = 1;

  state_t               state;
  state_t               state_nxt;
  logic [WORD_SIZE-1:0] base;
  logic [WORD_SIZE:0]   len;
  logic [WORD_SIZE:0]   count;
  logic                 last_beat;

  // The counter is reused: beats accepted during LOAD, words read during VERIFY.
  assign last_beat = in_valid && ((count + ONE) == len);

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == FLUSH) || (state == VERIFY);
  assign cpu_hold = busy;
  assign done     = (state == DONE);

`ifdef MEM_LOADER_VERIFY_EN
  logic [WORD_SIZE-1:0] rb_sum;
  logic                 verify_err_r;
  assign verify_err = verify_err_r;
`else
  logic unused_rd;
  assign unused_rd  = ^mem_data_out;
  assign verify_err = 1'b0;
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start is only honoured while idle or done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (length == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
`ifdef MEM_LOADER_VERIFY_EN
        state_nxt = VERIFY;
`else
        state_nxt = DONE;
`endif
      end
      VERIFY: begin
`ifdef MEM_LOADER_VERIFY_EN
        if (count == len) state_nxt = DONE;
`else
        state_nxt = DONE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on start, register memory writes, accumulate checksums.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base         <= '0;
      len          <= '0;
      count        <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_write    <= 1'b0;
      checksum     <= '0;
`ifdef MEM_LOADER_VERIFY_EN
      rb_sum       <= '0;
      verify_err_r <= 1'b0;
`endif
    end else begin
      mem_write <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            base     <= base_addr;
            len      <= length;
            count    <= '0;
            checksum <= '0;
`ifdef MEM_LOADER_VERIFY_EN
            verify_err_r <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            mem_address <= base + count[WORD_SIZE-1:0];
            mem_data_in <= in_data;
            mem_write   <= 1'b1;
            checksum    <= checksum + in_data;
            count       <= count + ONE;
          end
        end
`ifdef MEM_LOADER_VERIFY_EN
        FLUSH: begin
          // The final write lands at the end of this cycle; start reading at base.
          mem_address <= base;
          count       <= '0;
          rb_sum      <= '0;
        end
        VERIFY: begin
          if (count == len) begin
            verify_err_r <= (rb_sum != checksum);
          end else begin
            rb_sum      <= rb_sum + mem_data_out;
            mem_address <= base + count[WORD_SIZE-1:0] + 1'b1;
            count       <= count + ONE;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed steps, a behavioural memory,
// and a scoreboard of expected (address, data) writes.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic [7:0] mem_data_out;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic       verify_err;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  logic [15:0] sb[$];
  logic [7:0]  bytes [0:7];
  logic [7:0]  mem [0:255];
  logic        poke = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [7:0]  poke_val = '0;

  mem_loader #(.WORD_SIZE(8), .MEM_SIZE(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .checksum(checksum), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  // Memory_Unit model: synchronous write, asynchronous read, bench poke port.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
    else if (poke) mem[poke_addr] <= poke_val;
  end
  assign mem_data_out = mem[mem_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      logic [15:0] e;
      pulses++;
      check("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_address), 32'(e[15:8]));
        check("wr_data", 32'(mem_data_in), 32'(e[7:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_poke(input logic [7:0] a, input logic [7:0] v);
    poke = 1'b1; poke_addr = a; poke_val = v;
    step();
    poke = 1'b0;
  endtask

  // Start a load and stream n bytes from 'bytes'; optional idle cycle before each beat.
  task automatic do_load(input logic [7:0] b, input int n, input bit stall);
    logic [7:0] a;
    pulses = 0;
    start = 1'b1; base_addr = b; length = n[8:0];
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        in_valid = 1'b0;
        start = 1'b1; base_addr = 8'h77;   // must be ignored mid-load
        step();
        start = 1'b0; base_addr = b;
      end
      a = b + 8'(i);
      in_valid = 1'b1; in_data = bytes[i];
      sb.push_back({a, bytes[i]});
      check("in_ready_load", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_done", 32'(done), 32'd0);
  endtask

  // Move from FLUSH to DONE and check the completion outputs.
  task automatic finish_load(input logic [7:0] exp_sum, input int n, input bit exp_err);
`ifdef MEM_LOADER_VERIFY_EN
    for (int c = 0; c < 40; c++) begin
      if (done) break;
      step();
    end
    check("verify_err", 32'(verify_err), 32'(exp_err));
`else
    step();
    check("verify_err_tied", 32'(verify_err), 32'(exp_err));
`endif
    check("done", 32'(done), 32'd1);
    check("cpu_hold_done", 32'(cpu_hold), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("checksum", 32'(checksum), 32'(exp_sum));
    check("pulses", 32'(pulses), 32'(n));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    in_data = '0; in_valid = 1'b0;

    // Reset
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_verify_err", 32'(verify_err), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b1;
    step();

    // Basic back-to-back load
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'h01;
    do_load(8'h0A, 3, 1'b0);
    finish_load(8'h00, 3, 1'b0);
    check("mem_0A", 32'(mem[8'h0A]), 32'h55);
    check("mem_0B", 32'(mem[8'h0B]), 32'hAA);
    check("mem_0C", 32'(mem[8'h0C]), 32'h01);

    // Same load with stalls; memory cleared first
    do_poke(8'h0A, 8'h00); do_poke(8'h0B, 8'h00); do_poke(8'h0C, 8'h00);
    do_load(8'h0A, 3, 1'b1);
    finish_load(8'h00, 3, 1'b0);
    check("stall_mem_0A", 32'(mem[8'h0A]), 32'h55);
    check("stall_mem_0B", 32'(mem[8'h0B]), 32'hAA);
    check("stall_mem_0C", 32'(mem[8'h0C]), 32'h01);

    // Address wrap
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    do_load(8'hFE, 4, 1'b0);
    finish_load(8'hAA, 4, 1'b0);
    check("wrap_FE", 32'(mem[8'hFE]), 32'h11);
    check("wrap_FF", 32'(mem[8'hFF]), 32'h22);
    check("wrap_00", 32'(mem[8'h00]), 32'h33);
    check("wrap_01", 32'(mem[8'h01]), 32'h44);

    // Zero length
    pulses = 0;
    start = 1'b1; base_addr = 8'h40; length = 9'd0;
    step();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_checksum", 32'(checksum), 32'd0);
    step();
    check("zero_pulses", 32'(pulses), 32'd0);

`ifdef MEM_LOADER_VERIFY_EN
    // Clean verify
    bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30;
    do_load(8'h20, 3, 1'b0);
    finish_load(8'h60, 3, 1'b0);

    // Corrupted verify: overwrite 0x21 during VERIFY cycle 0
    do_load(8'h20, 3, 1'b0);
    step();
    check("in_verify", 32'(busy), 32'd1);
    do_poke(8'h21, 8'hEE);
    finish_load(8'h60, 3, 1'b1);
`endif

    // Reset mid-LOAD
    bytes[0] = 8'h01; bytes[1] = 8'h02;
    pulses = 0;
    start = 1'b1; base_addr = 8'h80; length = 9'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = bytes[i];
      sb.push_back({8'h80 + 8'(i), bytes[i]});
      step();
    end
    rst = 1'b0;
    step();
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_checksum", 32'(checksum), 32'd0);
    check("midrst_mem_80", 32'(mem[8'h80]), 32'h01);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_pulses", 32'(pulses), 32'd2);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
